hyper_mvblck_sched: RTL and testbench

- Four-channel scheduler in front of the DRAM-to-LSAB block mover and the MCU page-align port.
- Each channel, one per LSAB section, posts a 32-bit word address and a 16-bit word length.
- The block splits each transfer into chunks of at most MAX_BLK words that never cross a 4096-word DRAM page.
- It obtains page alignment from the MCU, issues chunks to the block mover one at a time, and serves channels round-robin.

---
 rtl/hyper_mvblck_sched.sv | 179 +++++++++++++++++
 tb/tb_hyper_mvblck_sched.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hyper_mvblck_sched.sv
// Four-channel round-robin scheduler that splits DRAM-to-LSAB moves into page-safe chunks.
// Optional grant-wait counter: define HYPER_MVBLCK_SCHED_STALL_EN to build STALL_CNT.
module hyper_mvblck_sched #(
    parameter int MAX_BLK    = 24,
    parameter bit KEEP_ALIGN = 1'b1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [3:0]   REQ,
    input  logic [127:0] REQ_ADDR,
    input  logic [63:0]  REQ_LEN,
    output logic [3:0]   ACK,
    output logic [3:0]   DONE,
    output logic [11:0]  BLCK_START,
    output logic [4:0]   BLCK_COUNT_REQ,
    output logic [1:0]   BLCK_SECTION,
    output logic         BLCK_ISSUE,
    input  logic         BLCK_WORKING,
    output logic [19:0]  MCU_PAGE_ADDR,
    output logic         MCU_REQUEST_ALIGN,
    input  logic         MCU_GRANT_ALIGN,
    output logic [15:0]  STALL_CNT
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CALC    = 3'd1;
    localparam logic [2:0] S_ALIGN   = 3'd2;
    localparam logic [2:0] S_ISSUE   = 3'd3;
    localparam logic [2:0] S_WAIT_UP = 3'd4;
    localparam logic [2:0] S_WAIT_DN = 3'd5;
    localparam logic [2:0] S_ADV     = 3'd6;

    logic [2:0]  state;
    logic [31:0] cur_addr;
    logic [15:0] remaining;
    logic [1:0]  chan;
    logic [1:0]  rr_last;
    logic        working_q;

    logic [1:0]  pick;
    logic        pick_valid;
    logic [1:0]  cand;
    logic [12:0] room;
    logic        rem_small;
    logic        room_small;
    logic [4:0]  chunk;
    logic [31:0] next_addr;
    logic [15:0] next_rem;

    // Round-robin search starting just above the last channel served.
    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        pick       = rr_last;
        pick_valid = 1'b0;
        cand       = rr_last;
        for (int i = 1; i <= 4; i++) begin
            cand = rr_last + 2'(i);
            if (!pick_valid && REQ[cand]) begin
                pick       = cand;
                pick_valid = 1'b1;
            end
        end
    end

    // chunk = min(remaining, MAX_BLK, room); all candidates below 32 compare in 5 bits.
    assign room       = 13'd4096 - {1'b0, cur_addr[11:0]};
    assign rem_small  = remaining < 16'(MAX_BLK);
    assign room_small = room < 13'(MAX_BLK);

    always_comb begin
        chunk = 5'(MAX_BLK);
        if (rem_small && (!room_small || remaining[4:0] <= room[4:0]))
            chunk = remaining[4:0];
        else if (room_small)
            chunk = room[4:0];
    end

    assign next_addr = cur_addr + {27'd0, BLCK_COUNT_REQ};
    assign next_rem  = remaining - {11'd0, BLCK_COUNT_REQ};

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state             <= S_IDLE;
            cur_addr          <= 32'd0;
            remaining         <= 16'd0;
            chan              <= 2'd0;
            rr_last           <= 2'd3;
            working_q         <= 1'b0;
            ACK               <= 4'd0;
            DONE              <= 4'd0;
            BLCK_START        <= 12'd0;
            BLCK_COUNT_REQ    <= 5'd0;
            BLCK_SECTION      <= 2'd0;
            BLCK_ISSUE        <= 1'b0;
            MCU_PAGE_ADDR     <= 20'd0;
            MCU_REQUEST_ALIGN <= 1'b0;
        end else begin
            ACK        <= 4'd0;
            DONE       <= 4'd0;
            BLCK_ISSUE <= 1'b0;
            working_q  <= BLCK_WORKING;
            case (state)
                S_IDLE: begin
                    if (pick_valid) begin
                        cur_addr  <= REQ_ADDR[32*pick +: 32];
                        remaining <= REQ_LEN[16*pick +: 16];
                        chan      <= pick;
                        rr_last   <= pick;
                        ACK       <= 4'b0001 << pick;
                        state     <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (remaining == 16'd0) begin
                        DONE  <= 4'b0001 << chan;
                        state <= S_IDLE;
                    end else begin
                        BLCK_START     <= cur_addr[11:0];
                        BLCK_COUNT_REQ <= chunk;
                        BLCK_SECTION   <= chan;
                        MCU_PAGE_ADDR  <= cur_addr[31:12];
                        // Alignment still held means the page did not change since the last chunk.
                        if (MCU_REQUEST_ALIGN) begin
                            state <= S_ISSUE;
                        end else begin
                            MCU_REQUEST_ALIGN <= 1'b1;
                            state             <= S_ALIGN;
                        end
                    end
                end
                S_ALIGN: begin
                    if (MCU_GRANT_ALIGN)
                        state <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (!BLCK_WORKING) begin
                        BLCK_ISSUE <= 1'b1;
                        state      <= S_WAIT_UP;
                    end
                end
                S_WAIT_UP: begin
                    if (BLCK_WORKING)
                        state <= S_WAIT_DN;
                end
                S_WAIT_DN: begin
                    if (working_q && !BLCK_WORKING)
                        state <= S_ADV;
                end
                S_ADV: begin
                    cur_addr  <= next_addr;
                    remaining <= next_rem;
                    if (next_addr[11:0] == 12'd0 || KEEP_ALIGN == 1'b0 || next_rem == 16'd0)
                        MCU_REQUEST_ALIGN <= 1'b0;
                    state <= S_CALC;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef HYPER_MVBLCK_SCHED_STALL_EN
    logic [15:0] stall_cnt;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            stall_cnt <= 16'd0;
        end else if (((state == S_ALIGN && !MCU_GRANT_ALIGN) ||
                      (state == S_ISSUE && BLCK_WORKING)) && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign STALL_CNT = stall_cnt;
`else
    assign STALL_CNT = 16'h0000;
`endif

endmodule

// File: tb/tb_hyper_mvblck_sched.sv
// Scoreboard bench for hyper_mvblck_sched: directed transfers, expected events queued, monitor compares.
module tb_hyper_mvblck_sched;

    logic         CLK;
    logic         RST;
    logic [3:0]   REQ;
    logic [127:0] REQ_ADDR;
    logic [63:0]  REQ_LEN;
    logic [3:0]   ACK;
    logic [3:0]   DONE;
    logic [11:0]  BLCK_START;
    logic [4:0]   BLCK_COUNT_REQ;
    logic [1:0]   BLCK_SECTION;
    logic         BLCK_ISSUE;
    logic         BLCK_WORKING;
    logic [19:0]  MCU_PAGE_ADDR;
    logic         MCU_REQUEST_ALIGN;
    logic         MCU_GRANT_ALIGN;
    logic [15:0]  STALL_CNT;

`ifdef HYPER_MVBLCK_SCHED_STALL_EN
    localparam logic [15:0] EXP_STALL = 16'd5;
`else
    localparam logic [15:0] EXP_STALL = 16'd0;
`endif

    hyper_mvblck_sched dut (
        .CLK              (CLK),
        .RST              (RST),
        .REQ              (REQ),
        .REQ_ADDR         (REQ_ADDR),
        .REQ_LEN          (REQ_LEN),
        .ACK              (ACK),
        .DONE             (DONE),
        .BLCK_START       (BLCK_START),
        .BLCK_COUNT_REQ   (BLCK_COUNT_REQ),
        .BLCK_SECTION     (BLCK_SECTION),
        .BLCK_ISSUE       (BLCK_ISSUE),
        .BLCK_WORKING     (BLCK_WORKING),
        .MCU_PAGE_ADDR    (MCU_PAGE_ADDR),
        .MCU_REQUEST_ALIGN(MCU_REQUEST_ALIGN),
        .MCU_GRANT_ALIGN  (MCU_GRANT_ALIGN),
        .STALL_CNT        (STALL_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef enum logic [1:0] {EV_ACK, EV_ALIGN, EV_ISSUE, EV_DONE} ev_kind_t;

    typedef struct {
        ev_kind_t    kind;
        logic [1:0]  ch;
        logic [11:0] start;
        logic [4:0]  cnt;
        logic [19:0] page;
        int          gap;
    } ev_t;

    ev_t sb_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input ev_kind_t k, input logic [1:0] ch, input logic [11:0] st,
                        input logic [4:0] cnt, input logic [19:0] pg, input int gap);
        ev_t e;
        e.kind  = k;
        e.ch    = ch;
        e.start = st;
        e.cnt   = cnt;
        e.page  = pg;
        e.gap   = gap;
        sb_q.push_back(e);
    endtask

    task automatic exp_ack(input logic [1:0] ch);
        push(EV_ACK, ch, 12'd0, 5'd0, 20'd0, 0);
    endtask

    task automatic exp_align(input logic [19:0] pg);
        push(EV_ALIGN, 2'd0, 12'd0, 5'd0, pg, 0);
    endtask

    task automatic exp_issue(input logic [1:0] ch, input logic [11:0] st, input logic [4:0] cnt,
                             input logic [19:0] pg);
        push(EV_ISSUE, ch, st, cnt, pg, 0);
    endtask

    task automatic exp_done(input logic [1:0] ch, input int gap);
        push(EV_DONE, ch, 12'd0, 5'd0, 20'd0, gap);
    endtask

    function automatic logic [63:0] exp_val(input ev_t e);
        case (e.kind)
            EV_ACK, EV_DONE: exp_val = 64'(4'b0001 << e.ch);
            EV_ALIGN:        exp_val = 64'(e.page);
            default:         exp_val = 64'({e.ch, e.start, e.cnt, e.page});
        endcase
    endfunction

    // Monitor: every ACK/DONE/ISSUE pulse and every rising MCU_REQUEST_ALIGN consumes one expected event.
    int   mon_cyc  = 0;
    int   last_cyc = 0;
    logic align_prev = 1'b0;

    task automatic observe(input ev_kind_t kind, input logic [63:0] act, input string nm);
        ev_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s unexpected: got 0x%0h expected no event at %0t", nm, act, $time);
        end else begin
            e = sb_q.pop_front();
            check({nm, "_kind"}, 64'(kind), 64'(e.kind));
            check(nm, act, exp_val(e));
            if (e.gap != 0)
                check({nm, "_gap"}, 64'(mon_cyc - last_cyc), 64'(e.gap));
        end
        last_cyc = mon_cyc;
    endtask

    initial begin
        forever begin
            @(negedge CLK);
            mon_cyc++;
            if (!RST) begin
                align_prev = 1'b0;
            end else begin
                if (ACK != 4'd0)
                    observe(EV_ACK, 64'(ACK), "ack");
                if (MCU_REQUEST_ALIGN && !align_prev)
                    observe(EV_ALIGN, 64'(MCU_PAGE_ADDR), "align");
                if (BLCK_ISSUE) begin
                    check("issue_while_working", 64'(BLCK_WORKING), 64'd0);
                    observe(EV_ISSUE, 64'({BLCK_SECTION, BLCK_START, BLCK_COUNT_REQ, MCU_PAGE_ADDR}), "issue");
                end
                if (DONE != 4'd0)
                    observe(EV_DONE, 64'(DONE), "done");
                align_prev = MCU_REQUEST_ALIGN;
            end
        end
    end

    // Block mover model: WORKING rises two cycles after the issue pulse and stays high four cycles.
    initial begin
        BLCK_WORKING = 1'b0;
        forever begin
            @(negedge CLK);
            if (BLCK_ISSUE) begin
                @(negedge CLK);
                BLCK_WORKING = 1'b1;
                repeat (4) @(negedge CLK);
                BLCK_WORKING = 1'b0;
            end
        end
    end

    task automatic do_reset();
        RST = 1'b0;
        REQ = 4'd0;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
    endtask

    task automatic check_outputs_zero(input string nm);
        check(nm, 64'({ACK, DONE, BLCK_START, BLCK_COUNT_REQ, BLCK_SECTION, BLCK_ISSUE,
                       MCU_PAGE_ADDR, MCU_REQUEST_ALIGN}), 64'd0);
        check({nm, "_stall"}, 64'(STALL_CNT), 64'd0);
    endtask

    task automatic set_chan(input int ch, input logic [31:0] addr, input logic [15:0] len);
        REQ_ADDR[32*ch +: 32] = addr;
        REQ_LEN[16*ch +: 16]  = len;
    endtask

    // Drops each REQ bit as its DONE pulses; bounded so a stuck DUT still reaches the summary.
    task automatic run_until_done(input int n, input string tag);
        int seen = 0;
        int cyc  = 0;
        while (seen < n && cyc < 2000) begin
            @(negedge CLK);
            cyc++;
            if (DONE != 4'd0) begin
                REQ = REQ & ~DONE;
                seen++;
            end
        end
        if (seen < n)
            check({tag, "_timeout"}, 64'(seen), 64'(n));
    endtask

    initial begin
        int cyc;
        RST             = 1'b0;
        REQ             = 4'd0;
        REQ_ADDR        = 128'd0;
        REQ_LEN         = 64'd0;
        MCU_GRANT_ALIGN = 1'b1;
        repeat (3) @(negedge CLK);
        check_outputs_zero("reset_state");
        RST = 1'b1;
        @(negedge CLK);

        // Single chunk inside one page.
        set_chan(0, 32'h0000_1000, 16'd10);
        exp_ack(2'd0);
        exp_align(20'h00001);
        exp_issue(2'd0, 12'h000, 5'd10, 20'h00001);
        exp_done(2'd0, 0);
        REQ = 4'b0001;
        run_until_done(1, "ch0_single");

        // 60 words split 24/24/12 with one align handshake held across chunks.
        set_chan(2, 32'h0000_4000, 16'd60);
        exp_ack(2'd2);
        exp_align(20'h00004);
        exp_issue(2'd2, 12'h000, 5'd24, 20'h00004);
        exp_issue(2'd2, 12'h018, 5'd24, 20'h00004);
        exp_issue(2'd2, 12'h030, 5'd12, 20'h00004);
        exp_done(2'd2, 0);
        REQ = 4'b0100;
        run_until_done(1, "ch2_split");

        // Page crossing: 8 words to the end of page 2, fresh handshake, 12 words on page 3.
        set_chan(1, 32'h0000_2FF8, 16'd20);
        exp_ack(2'd1);
        exp_align(20'h00002);
        exp_issue(2'd1, 12'hFF8, 5'd8, 20'h00002);
        exp_align(20'h00003);
        exp_issue(2'd1, 12'h000, 5'd12, 20'h00003);
        exp_done(2'd1, 0);
        REQ = 4'b0010;
        run_until_done(1, "ch1_cross");

        // Round-robin from reset: all four requesting, then channels 0 and 2.
        do_reset();
        for (int n = 0; n < 4; n++) begin
            set_chan(n, 32'h0001_0000 + 32'(n * 16), 16'd1);
            exp_ack(2'(n));
            exp_align(20'h00010);
            exp_issue(2'(n), 12'(n * 16), 5'd1, 20'h00010);
            exp_done(2'(n), 0);
        end
        REQ = 4'b1111;
        run_until_done(4, "rr_all");

        set_chan(0, 32'h0002_0000, 16'd1);
        set_chan(2, 32'h0003_0005, 16'd1);
        exp_ack(2'd0);
        exp_align(20'h00020);
        exp_issue(2'd0, 12'h000, 5'd1, 20'h00020);
        exp_done(2'd0, 0);
        exp_ack(2'd2);
        exp_align(20'h00030);
        exp_issue(2'd2, 12'h005, 5'd1, 20'h00030);
        exp_done(2'd2, 0);
        REQ = 4'b0101;
        run_until_done(2, "rr_pair");

        // Zero length: DONE on the cycle after ACK (two edges after REQ is sampled), nothing else.
        set_chan(3, 32'h0005_0000, 16'd0);
        exp_ack(2'd3);
        exp_done(2'd3, 1);
        REQ = 4'b1000;
        run_until_done(1, "ch3_zero");

        // Reset while the first chunk of a 60-word transfer waits for WORKING to fall.
        set_chan(2, 32'h0000_4000, 16'd60);
        exp_ack(2'd2);
        exp_align(20'h00004);
        exp_issue(2'd2, 12'h000, 5'd24, 20'h00004);
        REQ = 4'b0100;
        cyc = 0;
        while (!BLCK_WORKING && cyc < 200) begin
            @(negedge CLK);
            cyc++;
        end
        if (!BLCK_WORKING)
            check("mid_reset_working_timeout", 64'(BLCK_WORKING), 64'd1);
        @(negedge CLK);
        RST = 1'b0;
        REQ = 4'd0;
        @(negedge CLK);
        check_outputs_zero("mid_reset_outputs");
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        repeat (10) @(negedge CLK);
        check("mid_reset_pending_events", 64'(sb_q.size()), 64'd0);

        // Grant held low for five ALIGN cycles.
        do_reset();
        MCU_GRANT_ALIGN = 1'b0;
        set_chan(0, 32'h0000_0000, 16'd1);
        exp_ack(2'd0);
        exp_align(20'h00000);
        exp_issue(2'd0, 12'h000, 5'd1, 20'h00000);
        exp_done(2'd0, 0);
        REQ = 4'b0001;
        cyc = 0;
        while (!MCU_REQUEST_ALIGN && cyc < 50) begin
            @(negedge CLK);
            cyc++;
        end
        if (!MCU_REQUEST_ALIGN)
            check("stall_align_timeout", 64'(MCU_REQUEST_ALIGN), 64'd1);
        repeat (5) @(negedge CLK);
        MCU_GRANT_ALIGN = 1'b1;
        run_until_done(1, "stall_xfer");
        check("stall_cnt", 64'(STALL_CNT), 64'(EXP_STALL));

        repeat (10) @(negedge CLK);
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
